// File: rtl/regfile_32x64.sv
// rtl/regfile_32x64.sv - 32x64 integer register file, index 31 reads as zero
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN
module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam logic [ADDR_WIDTH-1:0] XZR = ADDR_WIDTH'(NUM_REGS - 1);

  logic [NUM_REGS-2:0]   row_en;
  logic [DATA_WIDTH-1:0] regs_d  [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS-1];
  logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];

  // One-hot row decode; RegWrite gates first so an unknown index cannot enable a row.
  always_comb begin
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      row_en[i] = RegWrite & (WriteRegister == ADDR_WIDTH'(i));
      regs_d[i] = row_en[i] ? WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // The zero register has no storage; its read slot is a constant.
  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_view
    assign rd_view[g] = regs_q[g];
  end
  assign rd_view[NUM_REGS-1] = '0;

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp_wr;
  logic byp1;
  logic byp2;

  assign byp_wr = !reset && RegWrite && (WriteRegister != XZR);
  assign byp1   = byp_wr && (ReadRegister1 == WriteRegister);
  assign byp2   = byp_wr && (ReadRegister2 == WriteRegister);

  assign ReadData1 = byp1 ? WriteData : rd_view[ReadRegister1];
  assign ReadData2 = byp2 ? WriteData : rd_view[ReadRegister2];
`else
  assign ReadData1 = rd_view[ReadRegister1];
  assign ReadData2 = rd_view[ReadRegister2];
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// tb/tb_regfile_32x64.sv - self-checking bench for regfile_32x64
// Honors REGFILE_WRITE_BYPASS_EN to match the build of the design.
module tb_regfile_32x64;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  regfile_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  localparam logic [63:0] BASE = 64'h0123_4567_89AB_0000;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [63:0] model [32];
  logic [63:0] exp_q1 [$];
  logic [63:0] exp_q2 [$];
  int checks;
  int failures;

  function automatic logic [63:0] model_read(input bit rst, input bit we, input logic [4:0] wa,
                                             input logic [63:0] wd, input logic [4:0] ra);
    if (BYP && !rst && we && wa != 5'd31 && ra == wa) return wd;
    if (ra == 5'd31) return 64'h0;
    return model[ra];
  endfunction

  task automatic check(input string name, input logic [4:0] ra, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, ra, got, exp);
    end
  endtask

  // Drive one cycle; e1/e2 are the required read values during that cycle.
  task automatic cycle(input string name, input bit chk, input bit rst, input bit we,
                       input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2);
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
    if (chk) begin
      exp_q1.push_back(e1);
      exp_q2.push_back(e2);
    end
    @(negedge clk);
    if (chk) begin
      check({name, "_rd1"}, r1, ReadData1, exp_q1.pop_front());
      check({name, "_rd2"}, r2, ReadData2, exp_q2.pop_front());
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (we && wa !== 5'd31) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic mcycle(input string name, input bit rst, input bit we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    cycle(name, 1'b1, rst, we, wa, wd, r1, r2,
          model_read(rst, we, wa, wd, r1), model_read(rst, we, wa, wd, r2));
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      mcycle(name, 1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
    end
  endtask

  vec_t vecs [$];

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    // Stored contents are unknown before the first reset edge.
    @(posedge clk); #1;
    cycle("rst_a", 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0);
    cycle("rst_b", 1'b0, 1'b1, 1'b1, 5'd4, 64'h9, 5'd0, 5'd0, 64'h0, 64'h0);
    sweep("reset_sweep");

    for (int i = 0; i < 31; i++) begin
      mcycle("write_all", 1'b0, 1'b1, 5'(i), BASE + 64'(i), 5'(i), 5'(30 - i));
    end
    sweep("readback");

    vecs = '{
      '{0, 1, 5'd7,  64'h11, 5'd7, 5'd7, BYP ? 64'h11 : BASE + 64'd7, BYP ? 64'h11 : BASE + 64'd7},
      '{0, 1, 5'd7,  64'h22, 5'd7, 5'd7, BYP ? 64'h22 : 64'h11, BYP ? 64'h22 : 64'h11},
      '{0, 0, 5'd5,  64'hDEAD_BEEF_DEAD_BEEF, 5'd7, 5'd5, 64'h22, BASE + 64'd5},
      '{0, 0, 5'd5,  64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd5, BASE + 64'd5, BASE + 64'd5},
      '{0, 0, 5'd5,  64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd5, BASE + 64'd5, BASE + 64'd5},
      '{0, 0, 5'd5,  64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd5, BASE + 64'd5, BASE + 64'd5},
      '{0, 0, 5'bx,  64'hFFFF_0000_FFFF_0000, 5'd5, 5'd0, BASE + 64'd5, BASE},
      '{0, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 64'h0, BASE + 64'd30},
      '{0, 0, 5'd0,  64'h0, 5'd31, 5'd30, 64'h0, BASE + 64'd30},
      '{0, 1, 5'd3,  64'h55, 5'd3, 5'd3, BYP ? 64'h55 : BASE + 64'd3, BYP ? 64'h55 : BASE + 64'd3},
      '{1, 1, 5'd3,  64'hAA, 5'd3, 5'd3, 64'h55, 64'h55},
      '{0, 0, 5'd3,  64'h0,  5'd3, 5'd7, 64'h0, 64'h0}
    };

    // Sweep between XZR-write and the reset case confirms rows 0..30 are intact.
    for (int v = 0; v < vecs.size(); v++) begin
      cycle($sformatf("vec%0d", v), 1'b1, vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd,
            vecs[v].r1, vecs[v].r2, vecs[v].e1, vecs[v].e2);
      if (v == 8) sweep("after_xzr");
    end
    sweep("after_reset_write");

    mcycle("post_rst_wr", 1'b0, 1'b1, 5'd12, 64'hCAFE_F00D_1234_5678, 5'd12, 5'd0);
    cycle("post_rst_rd", 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 5'd12, 5'd12,
          64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678);
    mcycle("hold_rst", 1'b1, 1'b0, 5'd0, 64'h0, 5'd12, 5'd12);
    mcycle("hold_rst", 1'b1, 1'b1, 5'd12, 64'h77, 5'd12, 5'd12);
    cycle("held_rst_rd", 1'b1, 1'b0, 1'b0, 5'd0, 64'h0, 5'd12, 5'd31, 64'h0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
